// File: rtl/vga_sync_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_decoder
//  Description : Receive-side VGA timing decoder. Watches an hsync/vsync pair
//                synchronous to pix_clk, recovers the x/y raster position,
//                measures line/frame totals and sync widths, and declares
//                lock once timing repeats over consecutive frames.
//  Ports       :
//    pix_clk      in   pixel clock, all logic on rising edge
//    rst          in   asynchronous active-high reset
//    hsync_in     in   horizontal sync (polarity set by HS_POL)
//    vsync_in     in   vertical sync (polarity set by VS_POL)
//    x, y         out  clocks since line start / lines since frame start
//    h_total      out  measured clocks per line
//    h_sync_w     out  measured hsync width in clocks
//    v_total      out  measured lines per frame
//    v_sync_w     out  measured vsync width in lines
//    line_start   out  one-cycle pulse per hsync assertion edge
//    frame_start  out  one-cycle pulse per vsync assertion edge
//    locked       out  timing stable for LOCK_FRAMES frames
//    lost         out  sticky: a position counter saturated
//  Revision    : 1.0  initial release
// ============================================================================
module vga_sync_decoder #(
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   LOCK_FRAMES = 2
) (
    input  logic        pix_clk,
    input  logic        rst,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic [11:0] h_total,
    output logic [11:0] h_sync_w,
    output logic [11:0] v_total,
    output logic [11:0] v_sync_w,
    output logic        line_start,
    output logic        frame_start,
    output logic        locked,
    output logic        lost
);

    localparam logic [11:0] c_SAT  = 12'hFFF;
    localparam logic [3:0]  c_LOCK = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_MEASURE = 2'd2,
        S_LOCKED  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        w_hs_a;
    logic        w_vs_a;
    logic        r_hs_q;
    logic        r_vs_q;
    logic        w_hs_rise;
    logic        w_hs_fall;
    logic        w_vs_rise;
    logic        w_vs_fall;

    logic [11:0] r_hw;
    logic [11:0] r_vw;
    logic [11:0] r_h_ref;
    logic [11:0] r_v_ref;
    logic [3:0]  r_match_cnt;
    logic [3:0]  w_match_nxt;
    logic        r_frame_bad;
    logic        r_skip_first;

    logic        w_x_sat;
    logic        w_y_sat;
    logic        w_sat;
    logic [11:0] w_x_inc;
    logic        w_line_bad;
    logic        w_frame_ok;

    logic        w_capture;
    logic        w_match_inc;
    logic        w_frame_end;
    logic        w_arm_exit;

    // Normalise to active-high before edge detection.
    assign w_hs_a    = (hsync_in == HS_POL);
    assign w_vs_a    = (vsync_in == VS_POL);
    assign w_hs_rise = w_hs_a & ~r_hs_q;
    assign w_hs_fall = ~w_hs_a & r_hs_q;
    assign w_vs_rise = w_vs_a & ~r_vs_q;
    assign w_vs_fall = ~w_vs_a & r_vs_q;

    assign w_x_sat     = (x == c_SAT);
    assign w_y_sat     = (y == c_SAT);
    assign w_sat       = w_x_sat | w_y_sat;
    // Line length after a saturated count is reported as the ceiling.
    assign w_x_inc     = w_x_sat ? c_SAT : (x + 12'd1);
    assign w_match_nxt = r_match_cnt + 4'd1;

    // A line ending on the same clock as the frame edge still belongs to the
    // finishing frame, so it is folded into the frame verdict directly.
    assign w_line_bad = ((r_state == S_MEASURE) || (r_state == S_LOCKED))
                        && w_hs_rise && !r_skip_first && (w_x_inc != r_h_ref);
    assign w_frame_ok = (y == r_v_ref) && !(r_frame_bad | w_line_bad);

    // ------------------------------------------------------------------------
    // Raster position and measurements
    // ------------------------------------------------------------------------
    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            r_hs_q      <= 1'b0;
            r_vs_q      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            x           <= '0;
            y           <= '0;
            h_total     <= '0;
            h_sync_w    <= '0;
            v_total     <= '0;
            v_sync_w    <= '0;
            r_hw        <= '0;
            r_vw        <= '0;
        end else begin
            r_hs_q      <= w_hs_a;
            r_vs_q      <= w_vs_a;
            line_start  <= w_hs_rise;
            frame_start <= w_vs_rise;

            if (w_hs_rise) begin
                x       <= '0;
                h_total <= w_x_inc;
            end else if (!w_x_sat) begin
                x <= x + 12'd1;
            end

            if (w_hs_rise) begin
                r_hw <= 12'd1;
            end else if (w_hs_a && (r_hw != c_SAT)) begin
                r_hw <= r_hw + 12'd1;
            end
            if (w_hs_fall) begin
                h_sync_w <= r_hw;
            end

            // A coincident hsync edge opens line 1 of the new frame.
            if (w_vs_rise) begin
                v_total <= y;
                y       <= {11'd0, w_hs_rise};
            end else if (w_hs_rise && !w_y_sat) begin
                y <= y + 12'd1;
            end

            if (w_vs_rise) begin
                r_vw <= {11'd0, w_hs_rise};
            end else if (w_vs_a && w_hs_rise && (r_vw != c_SAT)) begin
                r_vw <= r_vw + 12'd1;
            end
            if (w_vs_fall) begin
                v_sync_w <= r_vw;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Lock state machine
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_match_inc = 1'b0;
        w_frame_end = 1'b0;
        w_arm_exit  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // First frame is partial; only its end edge is used.
                if (w_vs_rise) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                if (w_vs_rise) begin
                    w_state_nxt = S_MEASURE;
                    w_capture   = 1'b1;
                    w_frame_end = 1'b1;
                    w_arm_exit  = 1'b1;
                end
            end
            S_MEASURE: begin
                if (w_vs_rise) begin
                    w_frame_end = 1'b1;
                    if (w_frame_ok) begin
                        w_match_inc = 1'b1;
                        if (w_match_nxt >= c_LOCK) begin
                            w_state_nxt = S_LOCKED;
                        end
                    end else begin
                        w_capture = 1'b1;
                    end
                end
            end
            S_LOCKED: begin
                if (w_vs_rise) begin
                    w_frame_end = 1'b1;
                    if (!w_frame_ok) begin
                        w_state_nxt = S_MEASURE;
                        w_capture   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Loss of sync overrides any frame-edge decision.
        if (w_sat) begin
            w_state_nxt = S_IDLE;
            w_capture   = 1'b0;
            w_match_inc = 1'b0;
            w_frame_end = 1'b0;
            w_arm_exit  = 1'b0;
        end
    end

    always_ff @(posedge pix_clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_h_ref      <= '0;
            r_v_ref      <= '0;
            r_match_cnt  <= '0;
            r_frame_bad  <= 1'b0;
            r_skip_first <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            locked  <= (w_state_nxt == S_LOCKED);

            if (w_sat) begin
                lost <= 1'b1;
            end else if ((w_state_nxt == S_LOCKED) && (r_state != S_LOCKED)) begin
                lost <= 1'b0;
            end

            if (w_sat) begin
                r_match_cnt  <= '0;
                r_frame_bad  <= 1'b0;
                r_skip_first <= 1'b0;
            end else begin
                if (w_capture) begin
                    r_v_ref     <= y;
                    r_h_ref     <= h_total;
                    r_match_cnt <= '0;
                end else if (w_match_inc) begin
                    r_match_cnt <= w_match_nxt;
                end

                if (w_frame_end) begin
                    r_frame_bad <= 1'b0;
                end else if (w_line_bad) begin
                    r_frame_bad <= 1'b1;
                end

                // The first line after arming may be partial; exempt it.
                if (w_arm_exit) begin
                    r_skip_first <= 1'b1;
                end else if (w_hs_rise &&
                             ((r_state == S_MEASURE) || (r_state == S_LOCKED))) begin
                    r_skip_first <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_decoder
//  Description : Self-checking bench for vga_sync_decoder. Two instances run
//                side by side, one with active-low and one with active-high
//                sync polarity, fed complementary versions of the same raster.
//                Reduced raster: 64 clocks/line, 8 clock hsync, 24 lines,
//                2 line vsync; vsync asserts together with an hsync edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_sync_decoder;

    localparam int c_H     = 64;
    localparam int c_HSW   = 8;
    localparam int c_V     = 24;
    localparam int c_VSW   = 2;
    localparam int c_SHORT = 5;

    typedef struct {
        logic exp_locked;
        logic exp_lost;
        bit   meas;
    } exp_t;

    logic        pix_clk;
    logic        clk_run;
    logic        rst;
    logic        hs_act;
    logic        vs_act;
    logic        hs_n;
    logic        vs_n;

    logic [11:0] x_o  [2];
    logic [11:0] y_o  [2];
    logic [11:0] ht_o [2];
    logic [11:0] hw_o [2];
    logic [11:0] vt_o [2];
    logic [11:0] vw_o [2];
    logic        ls_o [2];
    logic        fs_o [2];
    logic        lk_o [2];
    logic        lo_o [2];

    exp_t        sb[$];
    int          n_checks;
    int          n_errors;

    assign hs_n = ~hs_act;
    assign vs_n = ~vs_act;

    vga_sync_decoder #(.HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(2)) dut_lo (
        .pix_clk(pix_clk), .rst(rst), .hsync_in(hs_n), .vsync_in(vs_n),
        .x(x_o[0]), .y(y_o[0]), .h_total(ht_o[0]), .h_sync_w(hw_o[0]),
        .v_total(vt_o[0]), .v_sync_w(vw_o[0]), .line_start(ls_o[0]),
        .frame_start(fs_o[0]), .locked(lk_o[0]), .lost(lo_o[0])
    );

    vga_sync_decoder #(.HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(2)) dut_hi (
        .pix_clk(pix_clk), .rst(rst), .hsync_in(hs_act), .vsync_in(vs_act),
        .x(x_o[1]), .y(y_o[1]), .h_total(ht_o[1]), .h_sync_w(hw_o[1]),
        .v_total(vt_o[1]), .v_sync_w(vw_o[1]), .line_start(ls_o[1]),
        .frame_start(fs_o[1]), .locked(lk_o[1]), .lost(lo_o[1])
    );

    initial pix_clk = 1'b0;
    always begin
        #5;
        if (clk_run) pix_clk = ~pix_clk;
    end

    // Drive nfr frames; the frame edge of each pushes its expected lock state.
    task automatic run_frames(input int nfr, input int short_frame,
                              input logic [15:0] lock_mask, input int meas_from,
                              input bit lost_before_lock);
        int   vs_idx;
        int   len;
        bit   lock_seen;
        bit   pushed;
        exp_t e;
        vs_idx    = 0;
        lock_seen = 0;
        for (int f = 0; f < nfr; f++) begin
            for (int l = 0; l < c_V; l++) begin
                len = ((f == short_frame) && (l == c_SHORT)) ? c_H - 1 : c_H;
                for (int c = 0; c < len; c++) begin
                    hs_act = (c < c_HSW);
                    vs_act = (l < c_VSW);
                    pushed = 0;
                    if (l == 0 && c == 0) begin
                        vs_idx++;
                        e.exp_locked = lock_mask[vs_idx[3:0]];
                        if (e.exp_locked) lock_seen = 1;
                        e.exp_lost = lost_before_lock && !lock_seen;
                        e.meas     = (vs_idx >= meas_from);
                        sb.push_back(e);
                        pushed = 1;
                    end
                    @(posedge pix_clk);
                    #1;
                    for (int k = 0; k < 2; k++) begin
                        n_checks++;
                        if (x_o[k] !== 12'(c)) begin
                            n_errors++;
                            $display("FAIL x dut%0d f%0d l%0d: got %0d expected %0d", k, f, l, x_o[k], c);
                        end
                        n_checks++;
                        if (y_o[k] !== 12'(l + 1)) begin
                            n_errors++;
                            $display("FAIL y dut%0d f%0d l%0d c%0d: got %0d expected %0d", k, f, l, c, y_o[k], l + 1);
                        end
                        n_checks++;
                        if (ls_o[k] !== (c == 0)) begin
                            n_errors++;
                            $display("FAIL line_start dut%0d f%0d l%0d c%0d: got %0b expected %0b", k, f, l, c, ls_o[k], (c == 0));
                        end
                    end
                    if (fs_o[0] === 1'b1 || fs_o[1] === 1'b1) begin
                        if (sb.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL frame_start spurious f%0d l%0d c%0d: got 1 expected 0", f, l, c);
                        end else begin
                            e = sb.pop_front();
                            for (int k = 0; k < 2; k++) begin
                                n_checks++;
                                if (fs_o[k] !== 1'b1) begin
                                    n_errors++;
                                    $display("FAIL frame_start dut%0d edge%0d: got %0b expected 1", k, vs_idx, fs_o[k]);
                                end
                                n_checks++;
                                if (lk_o[k] !== e.exp_locked) begin
                                    n_errors++;
                                    $display("FAIL locked dut%0d edge%0d: got %0b expected %0b", k, vs_idx, lk_o[k], e.exp_locked);
                                end
                                n_checks++;
                                if (lo_o[k] !== e.exp_lost) begin
                                    n_errors++;
                                    $display("FAIL lost dut%0d edge%0d: got %0b expected %0b", k, vs_idx, lo_o[k], e.exp_lost);
                                end
                                if (e.meas) begin
                                    n_checks++;
                                    if (ht_o[k] !== 12'(c_H)) begin
                                        n_errors++;
                                        $display("FAIL h_total dut%0d edge%0d: got %0d expected %0d", k, vs_idx, ht_o[k], c_H);
                                    end
                                    n_checks++;
                                    if (hw_o[k] !== 12'(c_HSW)) begin
                                        n_errors++;
                                        $display("FAIL h_sync_w dut%0d edge%0d: got %0d expected %0d", k, vs_idx, hw_o[k], c_HSW);
                                    end
                                    n_checks++;
                                    if (vt_o[k] !== 12'(c_V)) begin
                                        n_errors++;
                                        $display("FAIL v_total dut%0d edge%0d: got %0d expected %0d", k, vs_idx, vt_o[k], c_V);
                                    end
                                    n_checks++;
                                    if (vw_o[k] !== 12'(c_VSW)) begin
                                        n_errors++;
                                        $display("FAIL v_sync_w dut%0d edge%0d: got %0d expected %0d", k, vs_idx, vw_o[k], c_VSW);
                                    end
                                end
                            end
                        end
                    end
                    if (pushed) begin
                        n_checks++;
                        if (sb.size() != 0) begin
                            n_errors++;
                            $display("FAIL frame_start missing edge%0d: got 0 expected 1", vs_idx);
                            sb.delete();
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        hs_act = 1'b0;
        vs_act = 1'b0;
        repeat (3) @(posedge pix_clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({x_o[k], y_o[k], ht_o[k], hw_o[k], vt_o[k], vw_o[k],
                 ls_o[k], fs_o[k], lk_o[k], lo_o[k]} !== 76'd0) begin
                n_errors++;
                $display("FAIL reset_state dut%0d: got %h expected 0", k,
                         {x_o[k], y_o[k], ht_o[k], hw_o[k], vt_o[k], vw_o[k],
                          ls_o[k], fs_o[k], lk_o[k], lo_o[k]});
            end
        end
        @(negedge pix_clk);
        rst = 1'b0;
    endtask

    // Lock after the 4th frame edge; measurements valid from the 2nd.
    task automatic test_nominal();
        run_frames(5, -1, 16'h0030, 2, 1'b0);
    endtask

    // One 63-clock line: unlock at the next edge, relock two edges later.
    task automatic test_short_line();
        run_frames(4, 0, 16'h0012, 1, 1'b0);
    endtask

    task automatic test_saturation();
        int n;
        hs_act = 1'b0;
        vs_act = 1'b0;
        n = 0;
        while (x_o[0] !== 12'hFFF && n < 5000) begin
            @(posedge pix_clk);
            #1;
            n++;
        end
        n_checks++;
        if (x_o[0] !== 12'hFFF) begin
            n_errors++;
            $display("FAIL x_saturate_timeout: got %0d expected 4095", x_o[0]);
        end
        // The saturated count is acted on one clock after it appears.
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (lk_o[k] !== 1'b1) begin
                n_errors++;
                $display("FAIL locked_at_sat_edge dut%0d: got %0b expected 1", k, lk_o[k]);
            end
        end
        repeat (10) begin
            @(posedge pix_clk);
            #1;
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (x_o[k] !== 12'hFFF) begin
                n_errors++;
                $display("FAIL x_hold_sat dut%0d: got %0d expected 4095", k, x_o[k]);
            end
            n_checks++;
            if (lk_o[k] !== 1'b0) begin
                n_errors++;
                $display("FAIL locked_after_sat dut%0d: got %0b expected 0", k, lk_o[k]);
            end
            n_checks++;
            if (lo_o[k] !== 1'b1) begin
                n_errors++;
                $display("FAIL lost_after_sat dut%0d: got %0b expected 1", k, lo_o[k]);
            end
        end
    endtask

    // The first edge coincides with the saturated count and is swallowed, so
    // lock lands on the 5th edge; lost stays set until then.
    task automatic test_relock_after_lost();
        run_frames(6, -1, 16'h0060, 2, 1'b1);
    endtask

    task automatic test_midline_reset();
        hs_act = 1'b0;
        vs_act = 1'b0;
        repeat (20) begin
            @(posedge pix_clk);
            #1;
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (lk_o[k] !== 1'b1) begin
                n_errors++;
                $display("FAIL pre_reset_locked dut%0d: got %0b expected 1", k, lk_o[k]);
            end
        end
        @(negedge pix_clk);
        clk_run = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({x_o[k], y_o[k], ht_o[k], hw_o[k], vt_o[k], vw_o[k],
                 ls_o[k], fs_o[k], lk_o[k], lo_o[k]} !== 76'd0) begin
                n_errors++;
                $display("FAIL async_reset dut%0d: got %h expected 0", k,
                         {x_o[k], y_o[k], ht_o[k], hw_o[k], vt_o[k], vw_o[k],
                          ls_o[k], fs_o[k], lk_o[k], lo_o[k]});
            end
        end
        #3;
        rst = 1'b0;
        #1;
        clk_run = 1'b1;
    endtask

    task automatic test_relock_after_reset();
        run_frames(5, -1, 16'h0030, 2, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk_run  = 1'b1;
        rst      = 1'b1;
        hs_act   = 1'b0;
        vs_act   = 1'b0;
        test_reset();
        test_nominal();
        test_short_line();
        test_saturation();
        test_relock_after_lost();
        test_midline_reset();
        test_relock_after_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
